// File: rtl/inst_fetch_ctrl_if.sv
// Bundle of fetch-stage signals shared by the fetch sequencer and its
// surroundings: start control, instruction ROM port, redirect from
// execute, the IF/ID handshake toward decode, and run status.
interface inst_fetch_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [7:0]       imem_addr;
    logic [31:0]      imem_instr;
    logic             redirect_valid;
    logic [7:0]       redirect_addr;
    logic             if_valid;
    logic [31:0]      if_instr;
    logic [7:0]       if_pc;
    logic             id_ready;
    logic             halted;
    logic [CNT_W-1:0] fetch_count;

    // The fetch sequencer drives the ROM address and the IF/ID register.
    modport master (
        input  start,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_addr,
        input  id_ready,
        output imem_addr,
        output if_valid,
        output if_instr,
        output if_pc,
        output halted,
        output fetch_count
    );

    // The environment (ROM, execute, decode, run control) sees the other side.
    modport slave (
        output start,
        output imem_instr,
        output redirect_valid,
        output redirect_addr,
        output id_ready,
        input  imem_addr,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        input  halted,
        input  fetch_count
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer for the 64-word instruction ROM. Owns the program
// counter, presents it straight to the ROM, and registers each returned
// word into the IF/ID register under a valid/ready handshake with decode.
// Taken branches/jumps from execute flush the IF/ID register and re-point
// the PC. A run begins with a start pulse and ends once the last program
// word has been captured and handed to decode.
module inst_fetch_ctrl #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [7:0] LAST_PC  = 8'h4C,
    parameter int         CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    inst_fetch_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       pc_q, pc_d;
    logic             valid_q, valid_d;
    logic [31:0]      instr_q, instr_d;
    logic [7:0]       ipc_q, ipc_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] count_q, count_d;

    // State register; reset overrides everything, including a run in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-datapath decision: redirect beats capture, capture
    // happens whenever the IF/ID slot is empty or being drained, else stall.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        ipc_d    = ipc_q;
        count_d  = count_q;
        halted_d = halted_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                if (bus.redirect_valid) begin
                    pc_d    = bus.redirect_addr & 8'hFC;
                    valid_d = 1'b0;
                end else if (!valid_q || bus.id_ready) begin
                    instr_d = bus.imem_instr;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    if (pc_q == LAST_PC) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pc_q + 8'd4;
                    end
                end
            end

            HALT: begin
                if (bus.id_ready) begin
                    valid_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_d == HALT) && !valid_d) begin
            halted_d = 1'b1;
        end
    end

    // Datapath registers: PC, IF/ID contents, run status and capture counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= 32'h0;
            ipc_q    <= 8'h00;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.if_valid    = valid_q;
    assign bus.if_instr    = instr_q;
    assign bus.if_pc       = ipc_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: a default-parameter instance and a wrapping
// instance (RESET_PC=F8, LAST_PC=04), both fed from one ROM image and both
// tracked by a cycle-level behavioural model of the fetch rules.
module tb_inst_fetch_ctrl;

    typedef struct {
        bit          running;
        bit          done;
        logic [7:0]  pc;
        logic        valid;
        logic [31:0] instr;
        logic [7:0]  ipc;
        logic        hl;
        logic [15:0] cnt;
    } mdl_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic w_reset = 1'b1;
    logic [31:0] rom [0:63];
    mdl_t m, mw;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_fetch_ctrl_if #(.CNT_W(16)) bus ();
    inst_fetch_ctrl_if #(.CNT_W(16)) w_bus ();

    inst_fetch_ctrl #(.RESET_PC(8'h00), .LAST_PC(8'h4C), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus.master)
    );

    inst_fetch_ctrl #(.RESET_PC(8'hF8), .LAST_PC(8'h04), .CNT_W(16)) dut_wrap (
        .clk(clk), .reset(w_reset), .bus(w_bus.master)
    );

    assign bus.imem_instr   = rom[bus.imem_addr[7:2]];
    assign w_bus.imem_instr = rom[w_bus.imem_addr[7:2]];

    function automatic logic [65:0] dut_obs();
        return {bus.if_valid, bus.if_instr, bus.if_pc, bus.halted, bus.fetch_count, bus.imem_addr};
    endfunction

    function automatic logic [65:0] wrap_obs();
        return {w_bus.if_valid, w_bus.if_instr, w_bus.if_pc, w_bus.halted, w_bus.fetch_count, w_bus.imem_addr};
    endfunction

    function automatic logic [65:0] mdl_exp(input mdl_t s);
        return {s.valid, s.instr, s.ipc, s.hl, s.cnt, s.pc};
    endfunction

    // One clock of the fetch rules, applied to the model's own PC and ROM image.
    task automatic model_step(input mdl_t s, input logic rst, input logic [7:0] rpc,
                              input logic [7:0] lpc, input logic st, input logic rv,
                              input logic [7:0] ra, input logic rdy, output mdl_t n);
        n = s;
        if (rst) begin
            n.running = 0; n.done = 0; n.pc = rpc; n.valid = 0;
            n.instr = 32'h0; n.ipc = 8'h00; n.hl = 0; n.cnt = 16'h0;
            return;
        end
        if (!s.running && !s.done) begin
            if (st) n.running = 1;
        end else if (s.running) begin
            if (rv) begin
                n.pc = {ra[7:2], 2'b00};
                n.valid = 0;
            end else if (!s.valid || rdy) begin
                n.instr = rom[s.pc / 4];
                n.ipc = s.pc;
                n.valid = 1;
                n.cnt = s.cnt + 16'd1;
                if (s.pc == lpc) begin
                    n.running = 0;
                    n.done = 1;
                end else begin
                    n.pc = s.pc + 8'd4;
                end
            end
        end else if (rdy) begin
            n.valid = 0;
        end
        n.hl = n.done && !n.valid;
    endtask

    task automatic step();
        mdl_t n, nw;
        model_step(m, reset, 8'h00, 8'h4C, bus.start, bus.redirect_valid,
                   bus.redirect_addr, bus.id_ready, n);
        model_step(mw, w_reset, 8'hF8, 8'h04, w_bus.start, w_bus.redirect_valid,
                   w_bus.redirect_addr, w_bus.id_ready, nw);
        @(posedge clk);
        #1;
        m = n;
        mw = nw;
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.redirect_valid = 0; bus.redirect_addr = 8'h00; bus.id_ready = 1;
    endtask

    task automatic reset_and_start();
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
        step();
        bus.start = 1;
        step();
        bus.start = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        bus.start = 1;
        bus.redirect_valid = 1;
        step();
        step();
        checks++;
        if (dut_obs() !== mdl_exp(m)) begin
            failures++;
            $display("[TB] FAIL reset_model got %h expected %h", dut_obs(), mdl_exp(m));
        end
        checks++;
        if ({bus.if_valid, bus.halted, bus.fetch_count, bus.imem_addr, bus.if_pc, bus.if_instr} !== 58'h0) begin
            failures++;
            $display("[TB] FAIL reset_values got v=%b h=%b cnt=%h pc=%h ipc=%h ins=%h expected all zero",
                     bus.if_valid, bus.halted, bus.fetch_count, bus.imem_addr, bus.if_pc, bus.if_instr);
        end
        reset = 0;
        idle_inputs();
    endtask

    task automatic test_full_run();
        int cyc;
        reset_and_start();
        bus.id_ready = 1;
        for (cyc = 0; cyc < 40; cyc++) begin
            step();
            checks++;
            if (dut_obs() !== mdl_exp(m)) begin
                failures++;
                $display("[TB] FAIL full_run cycle %0d got %h expected %h", cyc, dut_obs(), mdl_exp(m));
            end
            if (cyc == 0) begin
                checks++;
                if ({bus.if_valid, bus.if_instr, bus.if_pc} !== {1'b1, 32'h00007033, 8'h00}) begin
                    failures++;
                    $display("[TB] FAIL first_capture got v=%b %h@%h expected 1 00007033@00",
                             bus.if_valid, bus.if_instr, bus.if_pc);
                end
            end
            if (m.hl) break;
        end
        checks++;
        if (bus.halted !== 1'b1 || bus.fetch_count !== 16'd20 || bus.if_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL run_end got halted=%b count=%0d valid=%b expected 1 20 0",
                     bus.halted, bus.fetch_count, bus.if_valid);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        reset_and_start();
        for (cyc = 0; cyc < 20 && !(m.valid && m.ipc == 8'h08); cyc++) step();
        checks++;
        if (!(bus.if_valid && bus.if_pc == 8'h08)) begin
            failures++;
            $display("[TB] FAIL bp_reach got v=%b pc=%h expected 1 08", bus.if_valid, bus.if_pc);
        end
        bus.id_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (dut_obs() !== mdl_exp(m) || bus.if_instr !== 32'h00200113 || bus.imem_addr !== 8'h0C) begin
                failures++;
                $display("[TB] FAIL bp_hold got ins=%h addr=%h obs=%h expected ins=00200113 addr=0C obs=%h",
                         bus.if_instr, bus.imem_addr, dut_obs(), mdl_exp(m));
            end
        end
        bus.id_ready = 1;
        step();
        checks++;
        if (bus.if_instr !== 32'h00308193 || bus.if_pc !== 8'h0C || bus.fetch_count !== 16'd4) begin
            failures++;
            $display("[TB] FAIL bp_release got %h@%h cnt=%0d expected 00308193@0C cnt=4",
                     bus.if_instr, bus.if_pc, bus.fetch_count);
        end
    endtask

    task automatic test_redirect();
        int cyc;
        reset_and_start();
        for (cyc = 0; cyc < 20 && !(m.valid && m.ipc == 8'h10); cyc++) step();
        bus.redirect_valid = 1;
        bus.redirect_addr = 8'h23;
        step();
        bus.redirect_valid = 0;
        checks++;
        if (bus.if_valid !== 1'b0 || bus.imem_addr !== 8'h20 || dut_obs() !== mdl_exp(m)) begin
            failures++;
            $display("[TB] FAIL redirect_flush got v=%b addr=%h expected v=0 addr=20", bus.if_valid, bus.imem_addr);
        end
        step();
        checks++;
        if (bus.if_pc !== 8'h20 || bus.if_instr !== 32'h404404b3 || bus.fetch_count !== 16'd6) begin
            failures++;
            $display("[TB] FAIL redirect_target got %h@%h cnt=%0d expected 404404b3@20 cnt=6",
                     bus.if_instr, bus.if_pc, bus.fetch_count);
        end
    endtask

    task automatic test_redirect_stall();
        reset_and_start();
        step();
        bus.id_ready = 0;
        bus.redirect_valid = 1;
        bus.redirect_addr = 8'h30;
        step();
        checks++;
        if (bus.if_valid !== 1'b0 || bus.imem_addr !== 8'h30 || dut_obs() !== mdl_exp(m)) begin
            failures++;
            $display("[TB] FAIL stall_redirect got v=%b addr=%h expected v=0 addr=30", bus.if_valid, bus.imem_addr);
        end
        bus.redirect_valid = 0;
        bus.id_ready = 1;
        step();
        checks++;
        if ({bus.if_valid, bus.if_instr, bus.if_pc} !== {1'b1, 32'h0041a633, 8'h30}) begin
            failures++;
            $display("[TB] FAIL stall_redirect_capture got v=%b %h@%h expected 1 0041a633@30",
                     bus.if_valid, bus.if_instr, bus.if_pc);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] seq [0:3];
        int idx;
        logic [15:0] prev;
        seq[0] = 8'hF8; seq[1] = 8'hFC; seq[2] = 8'h00; seq[3] = 8'h04;
        w_bus.start = 0; w_bus.redirect_valid = 0; w_bus.redirect_addr = 8'h00; w_bus.id_ready = 1;
        w_reset = 1;
        step();
        w_reset = 0;
        w_bus.start = 1;
        step();
        w_bus.start = 0;
        idx = 0;
        for (int cyc = 0; cyc < 20 && !mw.hl; cyc++) begin
            prev = mw.cnt;
            step();
            checks++;
            if (wrap_obs() !== mdl_exp(mw)) begin
                failures++;
                $display("[TB] FAIL wrap_model cycle %0d got %h expected %h", cyc, wrap_obs(), mdl_exp(mw));
            end
            if (mw.cnt != prev && idx < 4) begin
                checks++;
                if (w_bus.if_pc !== seq[idx]) begin
                    failures++;
                    $display("[TB] FAIL wrap_seq[%0d] got %h expected %h", idx, w_bus.if_pc, seq[idx]);
                end
                idx++;
            end
        end
        checks++;
        if (w_bus.halted !== 1'b1 || w_bus.fetch_count !== 16'd4 || w_bus.imem_addr !== 8'h04) begin
            failures++;
            $display("[TB] FAIL wrap_halt got halted=%b cnt=%0d addr=%h expected 1 4 04",
                     w_bus.halted, w_bus.fetch_count, w_bus.imem_addr);
        end
    endtask

    task automatic test_reset_midrun();
        int cyc;
        reset_and_start();
        for (cyc = 0; cyc < 20 && !(m.valid && m.ipc == 8'h18); cyc++) step();
        reset = 1;
        bus.redirect_valid = 1;
        bus.redirect_addr = 8'h44;
        step();
        reset = 0;
        checks++;
        if (dut_obs() !== mdl_exp(m) || dut_obs() !== 66'h0) begin
            failures++;
            $display("[TB] FAIL midrun_reset got %h expected 0", dut_obs());
        end
        bus.redirect_addr = 8'h40;
        for (int i = 0; i < 3; i++) begin
            bus.id_ready = i[0];
            step();
            checks++;
            if (bus.imem_addr !== 8'h00 || bus.if_valid !== 1'b0 || bus.fetch_count !== 16'd0) begin
                failures++;
                $display("[TB] FAIL idle_ignore got addr=%h v=%b cnt=%0d expected 00 0 0",
                         bus.imem_addr, bus.if_valid, bus.fetch_count);
            end
        end
        bus.redirect_valid = 0;
        bus.id_ready = 1;
        bus.start = 1;
        step();
        bus.start = 0;
        for (cyc = 0; cyc < 60 && !m.hl; cyc++) step();
        bus.start = 1;
        bus.redirect_valid = 1;
        bus.redirect_addr = 8'h08;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.imem_addr !== 8'h4C || bus.halted !== 1'b1 || bus.fetch_count !== 16'd20 || dut_obs() !== mdl_exp(m)) begin
                failures++;
                $display("[TB] FAIL halt_ignore got addr=%h halted=%b cnt=%0d expected 4C 1 20",
                         bus.imem_addr, bus.halted, bus.fetch_count);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        reset_and_start();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.id_ready = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 9) == 0);
            bus.redirect_addr = 8'($urandom);
            bus.start = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 99) == 0);
            step();
            checks++;
            if (dut_obs() !== mdl_exp(m)) begin
                failures++;
                $display("[TB] FAIL random cycle %0d got %h expected %h", cyc, dut_obs(), mdl_exp(m));
            end
        end
        reset = 0;
        idle_inputs();
    endtask

    // Run every scenario in sequence, then print the summary.
    initial begin
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rom[0]  = 32'h00007033;
        rom[1]  = 32'h00100093;
        rom[2]  = 32'h00200113;
        rom[3]  = 32'h00308193;
        rom[8]  = 32'h404404b3;
        rom[12] = 32'h0041a633;
        rom[19] = 32'h02B02823;
        idle_inputs();
        w_bus.start = 0; w_bus.redirect_valid = 0; w_bus.redirect_addr = 8'h00; w_bus.id_ready = 1;
        test_reset();
        test_full_run();
        test_backpressure();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
